// File: rtl/tx_uart_if.sv
//------------------------------------------------------------------------------
// tx_uart_if -- handshake/serial bundle for tx_uart.
//   i_s_tick        : baud oversampling strobe (one clock wide)
//   i_tx_start      : frame start request
//   i_data          : byte to send, sampled on an accepted start
//   o_tx            : serial line, idle high
//   o_tx_done_tick  : one-cycle pulse on the first idle cycle after a frame
//   o_busy          : high while a frame is in progress
// master drives the request side, slave is the transmitter.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface tx_uart_if #(
    parameter int NB_DATA = 8
);
    logic               i_s_tick;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx;
    logic               o_tx_done_tick;
    logic               o_busy;

    modport master (
        output i_s_tick, i_tx_start, i_data,
        input  o_tx, o_tx_done_tick, o_busy
    );

    modport slave (
        input  i_s_tick, i_tx_start, i_data,
        output o_tx, o_tx_done_tick, o_busy
    );
endinterface

// File: rtl/tx_uart.sv
//------------------------------------------------------------------------------
// tx_uart -- UART transmitter driven by an external oversampling tick.
// Frame: start(0) + NB_DATA data bits LSB first [+ even parity] + stop(1).
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : tx_uart_if.slave (i_s_tick, i_tx_start, i_data,
//             o_tx, o_tx_done_tick, o_busy)
// Optional feature: define TX_UART_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop period.
// NB_COUNT must hold max(N_TICKS_PER_BIT, N_TICKS_TO_STOP)-1; the tick
// counter is cleared at every bit end and never wraps.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tx_uart #(
    parameter int NB_DATA         = 8,
    parameter int NB_COUNT        = 5,
    parameter int N_TICKS_PER_BIT = 16,
    parameter int N_TICKS_TO_STOP = 16
) (
    input logic       i_clock,
    input logic       i_reset,
    tx_uart_if.slave  bus
);
    localparam int NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_COUNT-1:0] BIT_END  = NB_COUNT'(N_TICKS_PER_BIT - 1);
    localparam logic [NB_COUNT-1:0] STOP_END = NB_COUNT'(N_TICKS_TO_STOP - 1);
    localparam logic [NB_BIT-1:0]   LAST_BIT = NB_BIT'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NB_COUNT-1:0] tick_q,  tick_d;
    logic [NB_BIT-1:0]   bit_q,   bit_d;
    logic [NB_DATA-1:0]  sh_q,    sh_d;
    logic                tx_q,    tx_d;
    logic                done_q,  done_d;
`ifdef TX_UART_PARITY_EN
    logic                par_q,   par_d;
`endif

    // State register (includes the registered line and done pulse)
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef TX_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef TX_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and datapath: everything holds unless a tick arrives,
    // except the start acceptance in IDLE.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
`ifdef TX_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_tx_start) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                    sh_d    = bus.i_data;
`ifdef TX_UART_PARITY_EN
                    // parity fixed at latch time; the shifter is consumed later
                    par_d   = ^bus.i_data;
`endif
                end
            end
            START: begin
                if (bus.i_s_tick) begin
                    if (tick_q == BIT_END) begin
                        state_d = DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d  = tick_q + NB_COUNT'(1);
                    end
                end
            end
            DATA: begin
                if (bus.i_s_tick) begin
                    if (tick_q == BIT_END) begin
                        tick_d = '0;
                        sh_d   = sh_q >> 1;
                        if (bit_q == LAST_BIT) begin
                            bit_d = '0;
`ifdef TX_UART_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + NB_BIT'(1);
                        end
                    end else begin
                        tick_d = tick_q + NB_COUNT'(1);
                    end
                end
            end
`ifdef TX_UART_PARITY_EN
            PARITY: begin
                if (bus.i_s_tick) begin
                    if (tick_q == BIT_END) begin
                        state_d = STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d  = tick_q + NB_COUNT'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.i_s_tick) begin
                    if (tick_q == STOP_END) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d  = tick_q + NB_COUNT'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bit_d   = '0;
                sh_d    = '0;
            end
        endcase
    end

    // Outputs: the line value is derived from the next state so o_tx is a
    // plain register that already shows the new bit on the cycle the state
    // changes.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = sh_d[0];
`ifdef TX_UART_PARITY_EN
            PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign bus.o_tx           = tx_q;
    assign bus.o_tx_done_tick = done_q;
    assign bus.o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tx_uart.sv
`timescale 1ns/1ps
module tb_tx_uart;
    localparam int NB_DATA = 8;
    localparam int TPB     = 16;
    localparam int TSTOP   = 16;
`ifdef TX_UART_PARITY_EN
    localparam int NPAR    = 1;
`else
    localparam int NPAR    = 0;
`endif
    localparam int NBITS       = 1 + NB_DATA + NPAR;      // bits before stop
    localparam int FRAME_TICKS = NBITS * TPB + TSTOP;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;

    tx_uart_if #(.NB_DATA(NB_DATA)) bus ();

    tx_uart #(
        .NB_DATA(NB_DATA), .NB_COUNT(5),
        .N_TICKS_PER_BIT(TPB), .N_TICKS_TO_STOP(TSTOP)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clock = ~i_clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // scoreboard: bytes of frames that must appear on the line, in order
    logic [7:0] sb_q[$];
    int exp_frames = 0;
    int done_seen  = 0;

    // tick generator: one strobe every 4 clocks, can be frozen
    bit tick_en    = 1'b1;
    int tick_total = 0;
    initial begin
        int div;
        div = 0;
        bus.i_s_tick = 1'b0;
        forever begin
            @(posedge i_clock);
            #1;
            div = (div + 1) % 4;
            bus.i_s_tick = tick_en && (div == 0);
            if (bus.i_s_tick) tick_total++;
        end
    end

    // monitor: samples the line once per tick and rebuilds whole frames
    logic samp[FRAME_TICKS];
    int   nsamp    = 0;
    bit   coll     = 1'b0;
    bit   just_done = 1'b0;
    int   busy_cnt = 0;

    task automatic check_frame();
        logic [7:0] d;
        logic       e;
        int         ones;
        d = 8'h00;
        chk("frame_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) d = sb_q.pop_front();
        for (int b = 0; b < NBITS; b++) begin
            if (b == 0)            e = 1'b0;
            else if (b <= NB_DATA) e = d[b-1];
            else                   e = ^d;
            ones = 0;
            for (int s = 0; s < TPB; s++) ones += int'(samp[b*TPB + s]);
            chk($sformatf("byte%02h_bit%0d_ones", d, b), ones, e ? TPB : 0);
        end
        ones = 0;
        for (int s = 0; s < TSTOP; s++) ones += int'(samp[NBITS*TPB + s]);
        chk($sformatf("byte%02h_stop_ones", d), ones, TSTOP);
        chk($sformatf("byte%02h_busy_ticks", d), busy_cnt, FRAME_TICKS);
    endtask

    initial begin
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                coll      = 1'b0;
                nsamp     = 0;
                just_done = 1'b0;
            end else begin
                chk("done_tick", int'(bus.o_tx_done_tick), int'(just_done));
                if (just_done) begin
                    chk("busy_at_done", int'(bus.o_busy), 0);
                    done_seen++;
                    just_done = 1'b0;
                end
                if (bus.i_s_tick) begin
                    if (!coll && bus.o_tx == 1'b0) begin
                        coll     = 1'b1;
                        nsamp    = 0;
                        busy_cnt = 0;
                    end
                    if (coll) begin
                        samp[nsamp] = bus.o_tx;
                        busy_cnt   += int'(bus.o_busy);
                        nsamp++;
                        if (nsamp == FRAME_TICKS) begin
                            coll      = 1'b0;
                            just_done = 1'b1;
                            check_frame();
                        end
                    end
                end
            end
        end
    end

    // stimulus helpers
    task automatic cyc(input int n);
        repeat (n) @(posedge i_clock);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input bit accept);
        @(posedge i_clock); #2;
        bus.i_data     = d;
        bus.i_tx_start = 1'b1;
        if (accept) begin
            sb_q.push_back(d);
            exp_frames++;
        end
        @(posedge i_clock); #2;
        bus.i_tx_start = 1'b0;
        bus.i_data     = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge i_clock); #2;
        while (bus.o_busy && n < 5000) begin
            @(posedge i_clock); #2;
            n++;
        end
        chk("idle_within_budget", int'(n < 5000), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(posedge i_clock); #2;
        while (!bus.o_tx_done_tick && n < 5000) begin
            @(posedge i_clock); #2;
            n++;
        end
        chk("done_within_budget", int'(n < 5000), 1);
    endtask

    task automatic wait_ticks(input int n);
        int tgt, g;
        tgt = tick_total + n;
        g   = 0;
        while (tick_total < tgt && g < 10000) begin
            @(posedge i_clock); #2;
            g++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, changes;
        logic v;
        logic [7:0] d;

        bus.i_tx_start = 1'b0;
        bus.i_data     = '0;
        i_reset        = 1'b0;
        cyc(3);
        chk("reset_tx",   int'(bus.o_tx), 1);
        chk("reset_busy", int'(bus.o_busy), 0);
        chk("reset_done", int'(bus.o_tx_done_tick), 0);
        i_reset = 1'b1;
        cyc(3);

        // single frame, plus two bytes with opposite parity
        send(8'hA5, 1'b1); wait_idle();
        send(8'h07, 1'b1); wait_idle();
        send(8'h03, 1'b1); wait_idle();
        cyc(5);

        // back-to-back: new start issued in the done cycle
        send(8'h00, 1'b1);
        wait_done();
        t1 = tick_total;
        bus.i_data     = 8'hFF;
        bus.i_tx_start = 1'b1;
        sb_q.push_back(8'hFF);
        exp_frames++;
        @(posedge i_clock); #2;
        bus.i_tx_start = 1'b0;
        wait_done();
        chk("b2b_done_gap_ticks", tick_total - t1, FRAME_TICKS);
        wait_idle();
        cyc(5);

        // start during a frame is ignored
        send(8'hC3, 1'b1);
        wait_ticks(TPB + 2*TPB + 5);
        send(8'h3C, 1'b0);
        wait_idle();
        cyc(5);

        // asynchronous reset during data bit 3
        send(8'($urandom), 1'b1);
        wait_ticks(TPB + 3*TPB + 8);
        @(posedge i_clock); #2;
        i_reset = 1'b0;
        #1;
        chk("async_reset_tx",   int'(bus.o_tx), 1);
        chk("async_reset_busy", int'(bus.o_busy), 0);
        void'(sb_q.pop_back());
        exp_frames--;
        cyc(3);
        i_reset = 1'b1;
        cyc(3);
        send(8'($urandom), 1'b1);
        wait_idle();
        cyc(5);

        // tick freeze mid-bit
        send(8'($urandom), 1'b1);
        wait_ticks(TPB + 2*TPB + 7);
        tick_en = 1'b0;
        cyc(2);
        v = bus.o_tx;
        changes = 0;
        repeat (100) begin
            @(posedge i_clock); #2;
            if (bus.o_tx !== v) changes++;
        end
        chk("freeze_tx_changes", changes, 0);
        tick_en = 1'b1;
        wait_idle();
        cyc(3);

        // randomized frames, random gaps, occasional ignored start
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send(d, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                wait_ticks($urandom_range(5, FRAME_TICKS - 20));
                send(8'($urandom), 1'b0);
            end
            wait_idle();
            cyc($urandom_range(0, 20));
        end

        cyc(10);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("done_pulse_count", done_seen, exp_frames);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
